// File: rtl/ram_stream_reader.sv
// Streams a contiguous RAM address range out over a registered valid/ready port.
// Define RAM_CLEAR_EN to add a sweep that writes zero to every RAM word.
module ram_stream_reader #(
  parameter int ADDRESS_SIZE = 10,
  parameter int DATA_SIZE    = 10,
  parameter int MEMORY_SIZE  = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDRESS_SIZE-1:0] base_addr,
  input  logic [ADDRESS_SIZE:0]   length,
  input  logic                    clear,
  output logic                    busy,
  output logic                    done,
  output logic [ADDRESS_SIZE-1:0] mem_address,
  output logic [DATA_SIZE-1:0]    mem_wdata,
  output logic                    mem_write,
  output logic                    mem_chip_select,
  input  logic [DATA_SIZE-1:0]    mem_rdata,
  output logic [DATA_SIZE-1:0]    out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);

  localparam logic [ADDRESS_SIZE-1:0] LAST_ADDR = ADDRESS_SIZE'(MEMORY_SIZE - 1);
  localparam logic [ADDRESS_SIZE:0]   MEM_WORDS = (ADDRESS_SIZE + 1)'(MEMORY_SIZE);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
`ifdef RAM_CLEAR_EN
    CLEAR,
`endif
    DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDRESS_SIZE-1:0] r_ptr;
  logic [ADDRESS_SIZE:0]   r_remaining;
  logic [DATA_SIZE-1:0]    r_out_data;
  logic                    r_out_valid;
  logic                    r_out_last;
  logic                    w_load;
  logic                    w_cs;
  logic                    w_we;
  logic [ADDRESS_SIZE-1:0] w_ptr_inc;

  assign w_ptr_inc = (r_ptr == LAST_ADDR) ? '0 : r_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_cs   = 1'b0;
    w_we   = 1'b0;
    case (r_state)
      IDLE: begin
`ifdef RAM_CLEAR_EN
        if (clear) w_next = CLEAR;
        else
`endif
        if (start) w_next = (length == '0) ? DONE : READ;
      end
      READ: begin
        w_cs   = 1'b1;
        w_load = !r_out_valid || out_ready;
        if (w_load && r_remaining == 1) w_next = DRAIN;
      end
      DRAIN: begin
        if (r_out_valid && out_ready) w_next = DONE;
      end
`ifdef RAM_CLEAR_EN
      CLEAR: begin
        w_cs = 1'b1;
        w_we = 1'b1;
        if (r_ptr == LAST_ADDR) w_next = DONE;
      end
`endif
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= '0;
      r_remaining <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
`ifdef RAM_CLEAR_EN
          if (clear) r_ptr <= '0;
          else
`endif
          if (start && length != '0) begin
            r_ptr       <= base_addr;
            r_remaining <= (length > MEM_WORDS) ? MEM_WORDS : length;
          end
        end
        READ: begin
          if (w_load) begin
            r_out_data  <= mem_rdata;
            r_out_valid <= 1'b1;
            r_out_last  <= (r_remaining == 1);
            r_ptr       <= w_ptr_inc;
            r_remaining <= r_remaining - 1'b1;
          end
        end
        DRAIN: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
          end
        end
`ifdef RAM_CLEAR_EN
        CLEAR: r_ptr <= w_ptr_inc;
`endif
        default: ;
      endcase
    end
  end

`ifndef RAM_CLEAR_EN
  logic w_unused_clear;
  assign w_unused_clear = clear;
`endif

  assign busy            = (r_state != IDLE);
  assign done            = (r_state == DONE);
  assign mem_address     = r_ptr;
  assign mem_chip_select = w_cs;
  assign mem_write       = w_we;
  assign mem_wdata       = '0;
  assign out_data        = r_out_data;
  assign out_valid       = r_out_valid;
  assign out_last        = r_out_last;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader with a behavioural RAM preloaded mem[a]=a.
// Covers stream reads, wrap, stalls, zero length, mid-command reset and the RAM_CLEAR_EN sweep.
module tb_ram_stream_reader;
  localparam int AW = 10;
  localparam int DW = 10;
  localparam int MS = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          clear;
  logic          busy, done;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata;
  logic          mem_write, mem_chip_select;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready, out_last;

  always #5 clk = ~clk;

  logic [DW-1:0] mem [MS];
  assign mem_rdata = mem[mem_address];
  always @(posedge clk) if (mem_chip_select && mem_write) mem[mem_address] <= mem_wdata;

  ram_stream_reader #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW), .MEMORY_SIZE(MS)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .clear(clear), .busy(busy), .done(done), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_chip_select(mem_chip_select),
    .mem_rdata(mem_rdata), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  int errors = 0;
  int checks = 0;
  logic [DW:0] exp_q[$];
  int hs_cnt = 0;
  int wr_cnt = 0;
  int wr_bad = 0;
  logic [AW-1:0] wr_exp_addr = '0;
  int ready_mode = 0;
  int patt[6] = '{1, 0, 0, 1, 0, 1};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ready driver: changes 2 time units after each rising edge
  initial begin
    int rcyc;
    rcyc = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      rcyc++;
      out_ready = (ready_mode == 0) ? 1'b1 : patt[rcyc % 6][0];
    end
  end

  // monitor/scoreboard: samples on the falling edge, values seen at the next rising edge
  initial begin
    logic        prev_stall;
    logic [DW:0] prev_word;
    logic [DW:0] w;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      if (reset) prev_stall = 1'b0;
      else begin
        if (prev_stall) begin
          check("stall_valid", int'(out_valid), 1);
          check("stall_hold", int'({out_last, out_data}), int'(prev_word));
        end
        if (out_valid && out_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) check("extra_beat", 1, 0);
          else begin
            w = exp_q.pop_front();
            check("beat", int'({out_last, out_data}), int'(w));
          end
          prev_stall = 1'b0;
        end else begin
          prev_stall = out_valid;
          prev_word  = {out_last, out_data};
        end
        if (mem_chip_select && mem_write) begin
          wr_cnt++;
          if (mem_address !== wr_exp_addr || mem_wdata !== '0) wr_bad++;
          wr_exp_addr = wr_exp_addr + 1'b1;
        end
      end
    end
  end

  task automatic push_beats(input int base, input int n, input bit zero);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] d;
      d = zero ? '0 : DW'((base + i) % MS);
      exp_q.push_back({(i == n - 1), d});
    end
  endtask

  task automatic pulse_start(input int base, input int len);
    @(posedge clk); #2;
    base_addr = AW'(base);
    length    = (AW + 1)'(len);
    start     = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  // returns falling-edge index (1 = first after start edge) of done and first out_valid
  task automatic wait_done(input string name, input int limit,
                           output int done_cyc, output int fv_cyc);
    done_cyc = 0;
    fv_cyc   = 0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk); #1;
      if (fv_cyc == 0 && out_valid) fv_cyc = c;
      if (done) begin
        done_cyc = c;
        check({name, "_busy_in_done"}, int'(busy), 1);
        break;
      end
    end
    if (done_cyc == 0) check({name, "_done_timeout"}, 0, 1);
    @(negedge clk); #1;
    check({name, "_done_1cyc"}, int'(done), 0);
    check({name, "_idle_busy"}, int'(busy), 0);
  endtask

  task automatic run_cmd(input string name, input int base, input int len, input int mode,
                         input int beats, input int exp_done, input int exp_fv, input bit zero);
    int h0, dc, fv;
    ready_mode = mode;
    push_beats(base, beats, zero);
    h0 = hs_cnt;
    pulse_start(base, len);
    wait_done(name, 5000, dc, fv);
    if (exp_done > 0) check({name, "_done_cycle"}, dc, exp_done);
    check({name, "_first_valid"}, fv, exp_fv);
    check({name, "_beats"}, hs_cnt - h0, beats);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    ready_mode = 0;
  endtask

  typedef struct {
    string name;
    int    base;
    int    len;
    int    mode;
    int    beats;
    int    done_cyc;
    int    fv_cyc;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   h0, dc, fv;
    vecs[0] = '{"basic",   5,    4,    0, 4,    6,    2};
    vecs[1] = '{"wrap",    1022, 4,    0, 4,    6,    2};
    vecs[2] = '{"stall",   5,    4,    1, 4,    0,    2};
    vecs[3] = '{"len0",    0,    0,    0, 0,    1,    0};
    vecs[4] = '{"len1",    1000, 1,    0, 1,    3,    2};
    vecs[5] = '{"clamp",   7,    1500, 0, 1024, 1026, 2};

    for (int i = 0; i < MS; i++) mem[i] = DW'(i);
    reset = 1'b1; start = 1'b0; clear = 1'b0; base_addr = '0; length = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_out", int'({out_valid, out_last, out_data}), 0);
    check("rst_mem_ctl", int'({mem_write, mem_chip_select}), 0);
    check("rst_mem_bus", int'({mem_wdata, mem_address}), 0);
    @(posedge clk); #2 reset = 1'b0;

    for (int i = 0; i < 6; i++)
      run_cmd(vecs[i].name, vecs[i].base, vecs[i].len, vecs[i].mode,
              vecs[i].beats, vecs[i].done_cyc, vecs[i].fv_cyc, 1'b0);

    // second start while busy must be ignored
    push_beats(50, 4, 1'b0);
    h0 = hs_cnt;
    pulse_start(50, 4);
    base_addr = AW'(300); length = (AW + 1)'(4); start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    wait_done("busy_start", 100, dc, fv);
    check("busy_start_beats", hs_cnt - h0, 4);
    check("busy_start_queue", exp_q.size(), 0);
    @(negedge clk); #1;
    check("busy_start_not_queued", int'(busy), 0);

    // reset during the 3rd beat of a 10-word read
    push_beats(20, 10, 1'b0);
    h0 = hs_cnt;
    pulse_start(20, 10);
    for (int c = 0; c < 100 && hs_cnt - h0 < 3; c++) begin
      @(negedge clk); #1;
    end
    check("rst_mid_reached", hs_cnt - h0, 3);
    reset = 1'b1;
    @(negedge clk); #1;
    check("rst_mid_valid", int'(out_valid), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_done", int'(done), 0);
    exp_q.delete();
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk); #1;
    check("rst_mid_no_done", int'(done), 0);
    run_cmd("after_rst", 40, 2, 0, 2, 4, 2, 1'b0);

`ifdef RAM_CLEAR_EN
    h0 = hs_cnt;
    @(posedge clk); #2;
    base_addr = AW'(5); length = (AW + 1)'(4); start = 1'b1; clear = 1'b1;
    @(posedge clk); #2 start = 1'b0; clear = 1'b0;
    wait_done("sweep", 2000, dc, fv);
    check("sweep_done_cycle", dc, MS + 1);
    check("sweep_no_valid", fv, 0);
    check("sweep_writes", wr_cnt, MS);
    check("sweep_write_order", wr_bad, 0);
    check("sweep_no_beats", hs_cnt - h0, 0);
    begin
      int nz;
      nz = 0;
      for (int i = 0; i < MS; i++) if (mem[i] != '0) nz++;
      check("sweep_mem_zero", nz, 0);
    end
    run_cmd("read_zero", 10, 3, 0, 3, 5, 2, 1'b1);
`else
    @(posedge clk); #2 clear = 1'b1;
    @(posedge clk); #2 clear = 1'b0;
    @(negedge clk); #1;
    check("clear_ignored", int'(busy), 0);
    check("no_writes", wr_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
